// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU select codes and FSM states.
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_FWD     = 3'b000;
    localparam logic [2:0] ALU_ADD     = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;
    localparam logic [2:0] ALU_JMP     = 3'b100;
    localparam logic [2:0] ALU_SEL_MAX = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for both requesters plus the shared ALU connection.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
);
    logic                  REQ0_VALID;
    logic [DATA_WIDTH-1:0] REQ0_DATA1;
    logic [DATA_WIDTH-1:0] REQ0_DATA2;
    logic [SEL_WIDTH-1:0]  REQ0_SELECT;
    logic                  REQ0_READY;
    logic                  RSP0_VALID;
    logic [DATA_WIDTH-1:0] RSP0_RESULT;
    logic                  RSP0_ZERO;

    logic                  REQ1_VALID;
    logic [DATA_WIDTH-1:0] REQ1_DATA1;
    logic [DATA_WIDTH-1:0] REQ1_DATA2;
    logic [SEL_WIDTH-1:0]  REQ1_SELECT;
    logic                  REQ1_READY;
    logic                  RSP1_VALID;
    logic [DATA_WIDTH-1:0] RSP1_RESULT;
    logic                  RSP1_ZERO;

    logic                  RSP_ERR;
    logic [DATA_WIDTH-1:0] ALU_DATA1;
    logic [DATA_WIDTH-1:0] ALU_DATA2;
    logic [SEL_WIDTH-1:0]  ALU_SELECT;
    logic [DATA_WIDTH-1:0] ALU_RESULT;
    logic                  ALU_ZERO;
    logic                  BUSY;
    logic                  GRANT;

    modport slave (
        input  REQ0_VALID, REQ0_DATA1, REQ0_DATA2, REQ0_SELECT,
        output REQ0_READY, RSP0_VALID, RSP0_RESULT, RSP0_ZERO,
        input  REQ1_VALID, REQ1_DATA1, REQ1_DATA2, REQ1_SELECT,
        output REQ1_READY, RSP1_VALID, RSP1_RESULT, RSP1_ZERO,
        output RSP_ERR, ALU_DATA1, ALU_DATA2, ALU_SELECT,
        input  ALU_RESULT, ALU_ZERO,
        output BUSY, GRANT
    );

    modport master (
        output REQ0_VALID, REQ0_DATA1, REQ0_DATA2, REQ0_SELECT,
        input  REQ0_READY, RSP0_VALID, RSP0_RESULT, RSP0_ZERO,
        output REQ1_VALID, REQ1_DATA1, REQ1_DATA2, REQ1_SELECT,
        input  REQ1_READY, RSP1_VALID, RSP1_RESULT, RSP1_ZERO,
        input  RSP_ERR, ALU_DATA1, ALU_DATA2, ALU_SELECT,
        output ALU_RESULT, ALU_ZERO,
        input  BUSY, GRANT
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant: on a tie the requester that did not win last time wins.
module rr_arbiter2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last,
    output logic [1:0] o_ready,
    output logic       o_winner
);

    logic w_winner;

    always_comb begin
        w_winner = 1'b0;
        if (i_valid0 && i_valid1) begin
            w_winner = ~i_last;
        end else if (i_valid1) begin
            w_winner = 1'b1;
        end
    end

    always_comb begin
        o_ready = '0;
        if (i_valid0 || i_valid1) begin
            o_ready = w_winner ? 2'b10 : 2'b01;
        end
    end

    assign o_winner = w_winner;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, hold operands for a settle
// window, capture RESULT/ZERO and return them as a one-cycle response pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SEL_WIDTH     = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    alu_arbiter_if.slave  bus
);

    localparam int                 CNT_W    = 3;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic                  r_grant;
    logic [DATA_WIDTH-1:0] r_data1;
    logic [DATA_WIDTH-1:0] r_data2;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic                  r_illegal;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_res0;
    logic [DATA_WIDTH-1:0] r_res1;
    logic                  r_zero0;
    logic                  r_zero1;
    logic                  r_err;

    logic [1:0]            w_arb_ready;
    logic                  w_winner;
    logic                  w_accept;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_d1;
    logic [DATA_WIDTH-1:0] w_d2;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_cap_res;
    logic                  w_cap_zero;

    rr_arbiter2 u_rr (
        .i_valid0 (bus.REQ0_VALID),
        .i_valid1 (bus.REQ1_VALID),
        .i_last   (r_last),
        .o_ready  (w_arb_ready),
        .o_winner (w_winner)
    );

    assign w_d1      = w_winner ? bus.REQ1_DATA1  : bus.REQ0_DATA1;
    assign w_d2      = w_winner ? bus.REQ1_DATA2  : bus.REQ0_DATA2;
    assign w_sel     = w_winner ? bus.REQ1_SELECT : bus.REQ0_SELECT;
    assign w_illegal = (w_sel > SEL_WIDTH'(ALU_SEL_MAX));
    assign w_accept  = (r_state == IDLE) && (|w_arb_ready);
    assign w_capture = (r_state == EXEC) && (r_cnt == CNT_LAST);

    // Illegal selects run a forward of zero on the ALU, but the reported result is forced
    // so the response never depends on what the ALU does with that code.
    assign w_cap_res  = r_illegal ? '0   : bus.ALU_RESULT;
    assign w_cap_zero = r_illegal ? 1'b1 : bus.ALU_ZERO;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = EXEC;
            EXEC:    if (w_capture) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_grant   <= 1'b0;
            r_data1   <= '0;
            r_data2   <= '0;
            r_sel     <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_res0    <= '0;
            r_res1    <= '0;
            r_zero0   <= 1'b0;
            r_zero1   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data1   <= w_illegal ? '0 : w_d1;
                r_data2   <= w_illegal ? '0 : w_d2;
                r_sel     <= w_illegal ? SEL_WIDTH'(ALU_FWD) : w_sel;
                r_illegal <= w_illegal;
                r_grant   <= w_winner;
                r_last    <= w_winner;
                r_cnt     <= '0;
            end
            if (r_state == EXEC) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_err <= r_illegal;
                if (r_grant) begin
                    r_res1  <= w_cap_res;
                    r_zero1 <= w_cap_zero;
                end else begin
                    r_res0  <= w_cap_res;
                    r_zero0 <= w_cap_zero;
                end
            end
            if (r_state == RESP) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.REQ0_READY  = (r_state == IDLE) && w_arb_ready[0];
    assign bus.REQ1_READY  = (r_state == IDLE) && w_arb_ready[1];
    assign bus.RSP0_VALID  = (r_state == RESP) && !r_grant;
    assign bus.RSP1_VALID  = (r_state == RESP) &&  r_grant;
    assign bus.RSP0_RESULT = r_res0;
    assign bus.RSP0_ZERO   = r_zero0;
    assign bus.RSP1_RESULT = r_res1;
    assign bus.RSP1_ZERO   = r_zero1;
    assign bus.RSP_ERR     = r_err;
    assign bus.ALU_DATA1   = r_data1;
    assign bus.ALU_DATA2   = r_data2;
    assign bus.ALU_SELECT  = r_sel;
    assign bus.BUSY        = (r_state != IDLE);
    assign bus.GRANT       = r_grant;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters: port 0 is the CPU execute stage, port 1 is the address/branch-offset unit.
- Arbitrates round-robin between the two ports.
- Latches the winner's operands and select code, and holds them on the ALU for a fixed settle window.
- Captures RESULT/ZERO into a register and returns them to the winning requester as a one-cycle response pulse.

Parameters:
- DATA_WIDTH, 8: operand and result width.
- SEL_WIDTH, 3: ALU select width.
- SETTLE_CYCLES, 1: full clock cycles the operands are held on the ALU before the result is captured. Range 1..7; ALU worst-case latency is 2 ns.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- REQ0_VALID  in  1  requester 0 has an operation.
- REQ0_DATA1  in  8  requester 0 operand 1.
- REQ0_DATA2  in  8  requester 0 operand 2.
- REQ0_SELECT  in  3  requester 0 ALU op code.
- REQ0_READY  out  1  arbiter accepts requester 0 this cycle.
- RSP0_VALID  out  1  one-cycle pulse: response for requester 0.
- RSP0_RESULT  out  8  captured ALU result for requester 0.
- RSP0_ZERO  out  1  captured ALU ZERO for requester 0.
- REQ1_VALID, REQ1_DATA1, REQ1_DATA2, REQ1_SELECT, REQ1_READY, RSP1_VALID, RSP1_RESULT, RSP1_ZERO: same as port 0, for requester 1.
- RSP_ERR  out  1  qualifies either RSPx_VALID: the select code was illegal.
- ALU_DATA1  out  8  to ALU DATA1.
- ALU_DATA2  out  8  to ALU DATA2.
- ALU_SELECT  out  3  to ALU SELECT.
- ALU_RESULT  in  8  from ALU RESULT.
- ALU_ZERO  in  1  from ALU ZERO.
- BUSY  out  1  high whenever the state is not IDLE.
- GRANT  out  1  index of the requester currently owning the ALU.

Behaviour:

Reset (RESET low at a rising edge):
- State returns to IDLE; any in-flight operation is dropped and no response is issued.
- All outputs are 0: ALU_DATA1=0, ALU_DATA2=0, ALU_SELECT=3'b000 (forward), RSPx_VALID=0, RSPx_RESULT=0, RSPx_ZERO=0, RSP_ERR=0, BUSY=0, GRANT=0.
- LAST pointer is set to 1, so requester 0 wins the first tie.

FSM states: IDLE, EXEC, RESP.

IDLE:
- REQx_READY is combinational and asserted only for the arbitration winner.
- Winner selection:
  - If only one VALID is high, that requester wins.
  - If both are high, the requester that is not LAST wins.
  - If neither is high, both READY are low.
- On the edge where VALID&READY are both high:
  - latch DATA1, DATA2, SELECT into the operand registers that drive the ALU_* ports;
  - set GRANT and LAST to the winner;
  - clear the counter;
  - move to EXEC.
- The non-winner's READY stays low; its VALID must stay high until accepted (requester rule, checked by bench assertion).

EXEC:
- ALU_* outputs hold the latched values; the counter increments each edge.
- On the edge where the counter equals SETTLE_CYCLES-1:
  - capture ALU_RESULT and ALU_ZERO into the granted port's RSP registers;
  - move to RESP.

RESP:
- RSP<GRANT>_VALID=1 for exactly one cycle; the next edge returns to IDLE.
- READY is low in EXEC and RESP.
- Timing: accept at edge t → response visible t+SETTLE_CYCLES → next accept no earlier than edge t+SETTLE_CYCLES+2.
- RSPx_RESULT and RSPx_ZERO hold their value until that port's next capture.

Illegal select (SELECT > 3'b100):
- The request is accepted, but ALU_SELECT is driven 3'b000 with both operands 0.
- The response carries RESULT=0, ZERO=1, RSP_ERR=1.
- RSP_ERR is 0 for legal selects.

ALU outputs in IDLE keep the last latched values; no toggling without an accepted request.

Decomposition:
- Shared include alu_defs.vh holds:
  - select constants: ALU_FWD=3'b000, ALU_ADD=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_JMP=3'b100, ALU_SEL_MAX=3'b100;
  - state encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module rr_arbiter2: combinational two-way grant from VALID0, VALID1 and LAST, producing the READY vector and the winner index.

Test Plan:
1. Reset, then REQ0 only (D1=12, D2=2, SEL=001) → READY0 high in IDLE; with SETTLE_CYCLES=1, RSP0_VALID pulses one cycle after accept with RESULT=14, ZERO=0, RSP_ERR=0; RSP1_VALID stays 0.
2. Both VALID from reset, REQ0 (14 AND 2), REQ1 (12 OR 2) → requester 0 served first (RESULT=2), then requester 1 (RESULT=14); GRANT 0→1; no overlap of RSP0_VALID and RSP1_VALID.
3. Both VALID held for 4 operations → grants alternate 0,1,0,1; each accept spaced SETTLE_CYCLES+2 edges apart; BUSY low only in IDLE cycles.
4. REQ1 SEL=100, then REQ1 SEL=110 → first response RESULT=0, ZERO=1, ERR=0; second response RESULT=0, ZERO=1, ERR=1, with ALU_SELECT=000 during its EXEC.
5. RESET low during EXEC of a REQ0 add → no RSP0_VALID pulse; all outputs 0; next tie goes to requester 0.
6. SETTLE_CYCLES=3, REQ0 ADD 255+1 → ALU operands held 3 cycles; response RESULT=0, ZERO=1 (wrap-around), visible 3 edges after accept.
